// File: rtl/input_sweep_collector_pkg.sv
// Shared types and constants for the input sweep collector.
// Optional MISR signature logic is enabled with INPUT_SWEEP_MISR_EN.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10
  localparam logic [15:0] MISR_POLY = 16'hB400;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // One Fibonacci MISR step: tap parity XOR data enters at bit 0
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    return {s[14:0], (^(s & MISR_POLY)) ^ d};
  endfunction

endpackage

// File: rtl/sweep_delay_line.sv
// Delays the {valid, idx} capture tag by DEPTH cycles so that a capture
// lines up with the DUT's output latency. DEPTH=0 is a wire.
module sweep_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  if (DEPTH == 0) begin : g_pass
    // clock and reset have no function when there is no storage
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_idx        = in_idx;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     idx_q [DEPTH];
    logic [W-1:0]     idx_d [DEPTH];

    // next stage contents: input enters stage 0, everything moves up one
    always_comb begin
      valid_d[0] = in_valid;
      idx_d[0]   = in_idx;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        idx_d[i]   = idx_q[i-1];
      end
    end

    // shift register storage, cleared by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) idx_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        idx_q   <= idx_d;
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];
  end

endmodule

// File: rtl/input_sweep_collector.sv
// Exhaustive input sweep driver and truth-table capture for a small
// combinational netlist, with a valid/ready hand-off of the table.
// Define INPUT_SWEEP_MISR_EN to add the 16-bit MISR signature port sig.
module input_sweep_collector
  import sweep_pkg::*;
#(
  parameter  int unsigned NUM_IN  = 6,
  parameter  int unsigned DUT_LAT = 0,
  localparam int unsigned TT_W    = tt_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [NUM_IN-1:0] pat,
  input  logic              dut_f,
  output logic              busy,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [TT_W-1:0]   tt_data,
  output logic              done
`ifdef INPUT_SWEEP_MISR_EN
  ,
  output logic [15:0]       sig
`endif
);

  localparam int unsigned     IDX_W    = NUM_IN + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_IN-1:0]   pat_q, pat_d;
  logic [TT_W-1:0]     tt_data_q, tt_data_d;
  logic                cap_valid;
  logic [IDX_W-1:0]    cap_idx;
`ifdef INPUT_SWEEP_MISR_EN
  logic [15:0]         sig_q, sig_d;
`endif

  sweep_delay_line #(
    .DEPTH (DUT_LAT),
    .W     (IDX_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state_q == SWEEP),
    .in_idx    (idx_q),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  // sequencing, pattern generation and capture of f into the table
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tt_data_d = tt_data_q;
`ifdef INPUT_SWEEP_MISR_EN
    sig_d     = sig_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SWEEP;
          idx_d     = '0;
          tt_data_d = '0;
`ifdef INPUT_SWEEP_MISR_EN
          sig_d     = MISR_SEED;
`endif
        end
      end
      SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = (DUT_LAT == 0) ? HOLD : DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // DRAIN ends on the capture of the last pattern rather than with a
      // separate counter; that capture arrives exactly DUT_LAT cycles in.
      DRAIN: begin
        if (cap_valid && (cap_idx == IDX_LAST)) state_d = HOLD;
      end
      HOLD: begin
        if (tt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cap_valid) begin
      tt_data_d[cap_idx[NUM_IN-1:0]] = dut_f;
`ifdef INPUT_SWEEP_MISR_EN
      sig_d = misr_step(sig_q, dut_f);
`endif
    end

    pat_d = (state_d == SWEEP) ? idx_d[NUM_IN-1:0] : '0;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pat_q     <= '0;
      tt_data_q <= '0;
`ifdef INPUT_SWEEP_MISR_EN
      sig_q     <= MISR_SEED;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      tt_data_q <= tt_data_d;
`ifdef INPUT_SWEEP_MISR_EN
      sig_q     <= sig_d;
`endif
    end
  end

  assign pat      = pat_q;
  assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
  assign tt_valid = (state_q == HOLD);
  assign done     = (state_q == HOLD) && tt_ready;
  assign tt_data  = tt_data_q;
`ifdef INPUT_SWEEP_MISR_EN
  assign sig      = sig_q;
`endif

endmodule
